// File: rtl/sha256_core_block_if.sv
// rtl/sha256_core_block_if.sv - start/round-input/digest bundle for sha256_core_block
// Optional SHA256_CORE_BUSY_EN adds the busy status signal.
interface sha256_core_block_if;
    logic         d_valid;
    logic [31:0]  Wt_i;
    logic [31:0]  Kt_i;
    logic         done;
    logic [255:0] digest_o;
`ifdef SHA256_CORE_BUSY_EN
    logic         busy;

    modport master (output d_valid, Wt_i, Kt_i, input done, digest_o, busy);
    modport slave  (input d_valid, Wt_i, Kt_i, output done, digest_o, busy);
`else
    modport master (output d_valid, Wt_i, Kt_i, input done, digest_o);
    modport slave  (input d_valid, Wt_i, Kt_i, output done, digest_o);
`endif
endinterface

// File: rtl/sha256_core_block.sv
// rtl/sha256_core_block.sv - single-block SHA-256 compression, one round per clock
// Optional SHA256_CORE_BUSY_EN drives bus.busy high in LOAD/ROUND/FINAL.
module sha256_core_block (
    input  logic                 clk,
    input  logic                 rst,
    sha256_core_block_if.slave   bus
);
    localparam logic [255:0] H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    state_t        state_q;
    logic [31:0]   a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [5:0]    t_q;
    logic          done_q;
    logic [255:0]  digest_q;
    logic [31:0]   sum0, sum1, ch, maj, t1, t2, a_d, e_d;

    always_comb begin
        sum0 = {a_q[1:0], a_q[31:2]} ^ {a_q[12:0], a_q[31:13]} ^ {a_q[21:0], a_q[31:22]};
        sum1 = {e_q[5:0], e_q[31:6]} ^ {e_q[10:0], e_q[31:11]} ^ {e_q[24:0], e_q[31:25]};
        ch   = (e_q & f_q) ^ (~e_q & g_q);
        maj  = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
        t1   = h_q + sum1 + ch + bus.Kt_i + bus.Wt_i;
        t2   = sum0 + maj;
        a_d  = t1 + t2;
        e_d  = d_q + t1;
    end

`ifdef SHA256_CORE_BUSY_EN
    logic busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else if ((state_q == IDLE || state_q == DONE) && bus.d_valid) begin
            busy_q <= 1'b1;
        end else if (state_q == FINAL) begin
            busy_q <= 1'b0;
        end
    end

    assign bus.busy = busy_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            digest_q <= '0;
            t_q      <= '0;
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.d_valid) begin
                        state_q <= LOAD;
                        done_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= H_INIT;
                    t_q     <= '0;
                    state_q <= ROUND;
                end
                ROUND: begin
                    h_q <= g_q;
                    g_q <= f_q;
                    f_q <= e_q;
                    e_q <= e_d;
                    d_q <= c_q;
                    c_q <= b_q;
                    b_q <= a_q;
                    a_q <= a_d;
                    t_q <= t_q + 6'd1;
                    if (t_q == 6'd63) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    // Always fold into the constant IV: each start is an independent single block.
                    digest_q <= {H_INIT[255:224] + a_q, H_INIT[223:192] + b_q,
                                 H_INIT[191:160] + c_q, H_INIT[159:128] + d_q,
                                 H_INIT[127:96]  + e_q, H_INIT[95:64]   + f_q,
                                 H_INIT[63:32]   + g_q, H_INIT[31:0]    + h_q};
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.done     = done_q;
    assign bus.digest_o = digest_q;
endmodule

// File: tb/tb_sha256_core_block.sv
// tb/tb_sha256_core_block.sv - bench for sha256_core_block against a full SHA-256 model
// Honours SHA256_CORE_BUSY_EN when defined.
module tb_sha256_core_block;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sha256_core_block_if bus ();

    sha256_core_block dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [7:0]  msg_q [$];
    logic [31:0] w_tb [64];
    logic [255:0] last_digest;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pad msg_q into one 512-bit block and expand it to W0..W63.
    task automatic build_block();
        logic [7:0]  b [64];
        logic [63:0] bit_len;
        logic [31:0] s0, s1;
        int len;
        len = msg_q.size();
        bit_len = 64'(len) * 64'd8;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < len; i++) b[i] = msg_q[i];
        b[len] = 8'h80;
        for (int i = 0; i < 8; i++) b[56 + i] = bit_len[63 - 8 * i -: 8];
        for (int i = 0; i < 16; i++) w_tb[i] = {b[4 * i], b[4 * i + 1], b[4 * i + 2], b[4 * i + 3]};
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w_tb[t - 15], 7) ^ rotr(w_tb[t - 15], 18) ^ (w_tb[t - 15] >> 3);
            s1 = rotr(w_tb[t - 2], 17) ^ rotr(w_tb[t - 2], 19) ^ (w_tb[t - 2] >> 10);
            w_tb[t] = w_tb[t - 16] + s0 + w_tb[t - 7] + s1;
        end
    endtask

    task automatic sha_model(output logic [255:0] dig);
        logic [31:0] hv [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        logic [31:0] v [8];
        logic [31:0] x1, x2;
        for (int i = 0; i < 8; i++) v[i] = hv[i];
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[t] + w_tb[t];
            x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i - 1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) dig[255 - 32 * i -: 32] = hv[i] + v[i];
    endtask

    task automatic sample(inout int done_hi, inout int busy_n);
        done_hi += int'(bus.done);
`ifdef SHA256_CORE_BUSY_EN
        busy_n += int'(bus.busy);
`endif
    endtask

    // Start a run with w_tb; optional d_valid pulses at rounds pa/pb; optional reset at round rst_at.
    task automatic run_block(input string tag, input int pa, input int pb, input int rst_at,
                             input logic [255:0] exp);
        int done_hi = 0;
        int busy_n = 0;
        @(negedge clk);
        bus.d_valid = 1'b1;
        @(negedge clk);
        bus.d_valid = 1'b0;
        sample(done_hi, busy_n);
        chk({tag, " held_digest"}, bus.digest_o, last_digest);
        @(negedge clk);
        sample(done_hi, busy_n);
        for (int t = 0; t < 64; t++) begin
            bus.Wt_i = w_tb[t];
            bus.Kt_i = k_tab[t];
            bus.d_valid = (t == pa || t == pb);
            if (t == rst_at) begin
                rst = 1'b1;
                #1;
                chk({tag, " rst_done"}, 256'(bus.done), 256'd0);
                chk({tag, " rst_digest"}, bus.digest_o, 256'd0);
`ifdef SHA256_CORE_BUSY_EN
                chk({tag, " rst_busy"}, 256'(bus.busy), 256'd0);
`endif
                bus.d_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                last_digest = '0;
                return;
            end
            @(negedge clk);
            sample(done_hi, busy_n);
        end
        bus.d_valid = 1'b0;
        bus.Wt_i = $urandom;
        bus.Kt_i = $urandom;
        chk({tag, " done_low_during_run"}, 256'(done_hi), 256'd0);
        @(negedge clk);
        chk({tag, " done_at_67"}, 256'(bus.done), 256'd1);
        chk({tag, " digest"}, bus.digest_o, exp);
`ifdef SHA256_CORE_BUSY_EN
        chk({tag, " busy_cycles"}, 256'(busy_n), 256'd66);
        chk({tag, " busy_done"}, 256'(bus.busy), 256'd0);
`endif
        last_digest = exp;
    endtask

    task automatic set_abc();
        msg_q = '{8'h61, 8'h62, 8'h63};
        build_block();
    endtask

    initial begin
        logic [255:0] ref_dig;
        int len;
        bus.d_valid = 1'b0;
        bus.Wt_i = '0;
        bus.Kt_i = '0;
        last_digest = '0;
        #2;
        chk("reset_done", 256'(bus.done), 256'd0);
        chk("reset_digest", bus.digest_o, 256'd0);
`ifdef SHA256_CORE_BUSY_EN
        chk("reset_busy", 256'(bus.busy), 256'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        set_abc();
        run_block("abc", -1, -1, -1, ABC_DIGEST);

        msg_q = {};
        build_block();
        run_block("empty_b2b", -1, -1, -1, EMPTY_DIGEST);

        set_abc();
        run_block("abc_dvalid_ignored", 10, 40, -1, ABC_DIGEST);

        run_block("abc_reset_mid", -1, -1, 30, ABC_DIGEST);
        chk("after_reset_done", 256'(bus.done), 256'd0);
        run_block("abc_after_reset", -1, -1, -1, ABC_DIGEST);

        for (int n = 0; n < 4; n++) begin
            len = (n == 0) ? 55 : int'($urandom_range(0, 55));
            msg_q = {};
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            build_block();
            sha_model(ref_dig);
            run_block($sformatf("random%0d_len%0d", n, len), -1, -1, -1, ref_dig);
        end

        repeat (3) @(negedge clk);
        chk("idle_done_held", 256'(bus.done), 256'd1);
        chk("idle_digest_held", bus.digest_o, last_digest);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
